ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

Pipelined control unit for the RV32I(M) core: decodes the instruction in ID, registers the control bundle into the ID/EX boundary, and owns hazard control for that boundary. It detects load-use hazards and stalls the front end, holds EX for multi-cycle M-extension ops, resolves branches in EX from ALU flags, and flushes the wrong-path instruction on redirect. It sits between the IF/ID register and the EX-stage datapath.

## Interface
Parameters:
- HAS_M, 1, enable MUL/DIV decode (0: funct7=0000001 R-type is illegal)
- MD_LATENCY, 4, EX occupancy of an M op in cycles (≥1)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_i  in  32  instruction in ID
- instr_valid_i  in  1  instr_i valid
- alu_zero_i / alu_lt_i / alu_ltu_i  in  1 each  EX ALU flags (rs1-rs2 ==0, signed <, unsigned <)
- stall_o  out  1  hold PC and IF/ID
- pcsrc_o  out  1  redirect PC to EX target (combinational)
- ex_valid_o  out  1  EX holds a real instruction
- ex_reg_write_o, ex_mem_write_o, ex_alu_src_o, ex_alu_a_pc_o, ex_jalr_o, ex_load_unsigned_o, ex_muldiv_o, ex_illegal_o  out  1 each
- ex_result_src_o  out  2  00 ALU, 01 mem, 10 PC+4, 11 imm
- ex_imm_src_o  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ex_alu_ctrl_o  out  4  ALU op
- ex_data_width_o  out  2  00 word, 01 half, 10 byte
- ex_md_op_o  out  3  funct3 of M op
- ex_rd_o  out  5  destination register

## Operation
- Decode (comb): opcodes R, load, I-arith, JALR, S, B, LUI, AUIPC, JAL. R: alu_ctrl={f7[5],f3}. I-arith: alu_ctrl={f3==101 & f7[5], f3}. Branch/JALR/JAL: alu_ctrl=1000 (sub). Loads/stores: width from f3[1:0], load_unsigned=f3[2]. AUIPC: alu_a_pc=1, alu_src=1, imm_src=100. Unknown opcode, bad load/store f3, or M op with HAS_M=0: illegal=1, reg_write=mem_write=0.
- Bubble = ex_valid=0 and every ex_* output 0.
- Writes/pcsrc gated by ex_valid: ex_reg_write_o/ex_mem_write_o are 0 when ex_valid=0.
- pcsrc_o = ex_valid & (jal | jalr | branch taken). Taken: beq zero; bne !zero; blt lt; bge !lt; bltu ltu; bgeu !ltu.
- Load-use: ex_valid & ex_result_src=01 & ex_rd≠0 & ex_rd matches an rs used by ID instr (rs1: all except LUI/AUIPC/JAL; rs2: R, S, B) & instr_valid_i.
- M hold: counter loads MD_LATENCY-1 when an M op enters EX; while counter≠0, ID/EX holds, stall_o=1, counter decrements.
- ID/EX next-state priority: (1) pcsrc_o=1 -> bubble, stall_o=0; (2) M hold -> keep; (3) load-use -> bubble, stall_o=1; (4) else capture decode (ex_valid=instr_valid_i).
- ex_rd_o forced 0 for S/B instrs.

## Timing
- Reset: all ex_* outputs 0, ex_valid 0, counter 0; stall_o=0, pcsrc_o=0 during and immediately after reset. Reset mid-M-op aborts it.
- Decode-to-EX latency 1 cycle. pcsrc_o same cycle as flags.
- Load-use: exactly one bubble, stall_o high one cycle.
- M op: occupies EX MD_LATENCY cycles; MD_LATENCY=1 never holds.
- Redirect during load-use: flush wins, no stall. Redirect cannot coincide with M hold (M ops never redirect).
- Back-to-back load-use after an M op: hold completes first, then hazard check against the load.

## Test plan
- Reset: rst_n low mid-stream -> all outputs 0 asynchronously; first instr after release appears in EX one cycle later.
- Load-use: lw x5,0(x1) then add x6,x5,x2 -> one bubble, stall_o=1 one cycle, add reaches EX cycle 3; lw x0 or unrelated rs -> no stall.
- Branches: each of beq/bne/blt/bge/bltu/bgeu with flag combos (zero,lt,ltu) -> pcsrc_o per table; taken -> next EX bubble.
- M op with MD_LATENCY=4: mul then add -> mul in EX 4 cycles, stall_o high 3, add enters EX cycle 5; HAS_M=0 -> ex_illegal_o=1, no write.
- Decode coverage: srai (f7=0100000,f3=101) -> alu_ctrl 1101; auipc -> alu_a_pc=1, imm_src=100; lbu -> width 10, unsigned 1; sw -> rd 0, mem_write 1.
- Flush priority: jal in EX while ID has load-use candidate -> pcsrc_o=1, stall_o=0, next EX bubble.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// ctrl_pipe_if : ID-stage instruction, EX flags and ID/EX control bundle
// Revision     : 1.0
// ============================================================================
interface ctrl_pipe_if;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic        alu_zero_i;
  logic        alu_lt_i;
  logic        alu_ltu_i;
  logic        stall_o;
  logic        pcsrc_o;
  logic        ex_valid_o;
  logic        ex_reg_write_o;
  logic        ex_mem_write_o;
  logic        ex_alu_src_o;
  logic        ex_alu_a_pc_o;
  logic        ex_jalr_o;
  logic        ex_load_unsigned_o;
  logic        ex_muldiv_o;
  logic        ex_illegal_o;
  logic [1:0]  ex_result_src_o;
  logic [2:0]  ex_imm_src_o;
  logic [3:0]  ex_alu_ctrl_o;
  logic [1:0]  ex_data_width_o;
  logic [2:0]  ex_md_op_o;
  logic [4:0]  ex_rd_o;

  modport master (
    output instr_i, instr_valid_i, alu_zero_i, alu_lt_i, alu_ltu_i,
    input  stall_o, pcsrc_o, ex_valid_o, ex_reg_write_o, ex_mem_write_o,
           ex_alu_src_o, ex_alu_a_pc_o, ex_jalr_o, ex_load_unsigned_o,
           ex_muldiv_o, ex_illegal_o, ex_result_src_o, ex_imm_src_o,
           ex_alu_ctrl_o, ex_data_width_o, ex_md_op_o, ex_rd_o
  );

  modport slave (
    input  instr_i, instr_valid_i, alu_zero_i, alu_lt_i, alu_ltu_i,
    output stall_o, pcsrc_o, ex_valid_o, ex_reg_write_o, ex_mem_write_o,
           ex_alu_src_o, ex_alu_a_pc_o, ex_jalr_o, ex_load_unsigned_o,
           ex_muldiv_o, ex_illegal_o, ex_result_src_o, ex_imm_src_o,
           ex_alu_ctrl_o, ex_data_width_o, ex_md_op_o, ex_rd_o
  );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// ctrl_pipe : RV32I(M) decode, ID/EX control register and hazard control
// Revision  : 1.0
// ============================================================================
module ctrl_pipe #(
  parameter bit HAS_M      = 1'b1,
  parameter int MD_LATENCY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  ctrl_pipe_if.slave bus
);

  localparam logic [6:0] c_op_r     = 7'b0110011;
  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_imm   = 7'b0010011;
  localparam logic [6:0] c_op_jalr  = 7'b1100111;
  localparam logic [6:0] c_op_s     = 7'b0100011;
  localparam logic [6:0] c_op_b     = 7'b1100011;
  localparam logic [6:0] c_op_lui   = 7'b0110111;
  localparam logic [6:0] c_op_auipc = 7'b0010111;
  localparam logic [6:0] c_op_jal   = 7'b1101111;

  localparam int c_cnt_w = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [c_cnt_w-1:0] c_md_load = c_cnt_w'(MD_LATENCY - 1);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       alu_a_pc;
    logic       jalr;
    logic       jal;
    logic       branch;
    logic       load_unsigned;
    logic       muldiv;
    logic       illegal;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;
    logic [1:0] data_width;
    logic [2:0] md_op;
    logic [2:0] br_f3;
    logic [4:0] rd;
  } ctrl_t;

  ctrl_t              r_ex;
  ctrl_t              w_dec;
  ctrl_t              w_ex_nxt;
  logic [c_cnt_w-1:0] r_md_cnt;

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;
  logic       w_bad;
  logic       w_use_rs1;
  logic       w_use_rs2;
  logic [1:0] w_width;
  logic       w_taken;
  logic       w_pcsrc;
  logic       w_md_hold;
  logic       w_load_use;
  logic       w_capture;

  assign w_op  = bus.instr_i[6:0];
  assign w_rd  = bus.instr_i[11:7];
  assign w_f3  = bus.instr_i[14:12];
  assign w_rs1 = bus.instr_i[19:15];
  assign w_rs2 = bus.instr_i[24:20];
  assign w_f7  = bus.instr_i[31:25];

  assign w_use_rs1 = !(w_op == c_op_lui || w_op == c_op_auipc || w_op == c_op_jal);
  assign w_use_rs2 = (w_op == c_op_r || w_op == c_op_s || w_op == c_op_b);

  // funct3[1:0] byte/half/word maps onto the 10/01/00 width encoding
  always_comb begin
    w_width = 2'b00;
    case (w_f3[1:0])
      2'b00:   w_width = 2'b10;
      2'b01:   w_width = 2'b01;
      default: w_width = 2'b00;
    endcase
  end

  always_comb begin
    w_dec = '0;
    w_bad = 1'b0;
    case (w_op)
      c_op_r: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_ctrl  = {w_f7[5], w_f3};
        w_dec.rd        = w_rd;
        if (w_f7 == 7'b0000001) begin
          if (HAS_M) begin
            w_dec.muldiv = 1'b1;
            w_dec.md_op  = w_f3;
          end else begin
            w_bad = 1'b1;
          end
        end
      end
      c_op_load: begin
        w_dec.reg_write     = 1'b1;
        w_dec.alu_src       = 1'b1;
        w_dec.result_src    = 2'b01;
        w_dec.data_width    = w_width;
        w_dec.load_unsigned = w_f3[2];
        w_dec.rd            = w_rd;
        w_bad               = (w_f3[1:0] == 2'b11) || (w_f3 == 3'b110);
      end
      c_op_imm: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_ctrl  = {(w_f3 == 3'b101) & w_f7[5], w_f3};
        w_dec.rd        = w_rd;
      end
      c_op_jalr: begin
        w_dec.reg_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.jalr       = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.alu_ctrl   = 4'b1000;
        w_dec.rd         = w_rd;
      end
      c_op_s: begin
        w_dec.mem_write  = 1'b1;
        w_dec.alu_src    = 1'b1;
        w_dec.imm_src    = 3'b001;
        w_dec.data_width = w_width;
        w_bad            = w_f3[2] || (w_f3[1:0] == 2'b11);
      end
      c_op_b: begin
        w_dec.branch   = 1'b1;
        w_dec.imm_src  = 3'b010;
        w_dec.alu_ctrl = 4'b1000;
        w_dec.br_f3    = w_f3;
      end
      c_op_lui: begin
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = 2'b11;
        w_dec.imm_src    = 3'b100;
        w_dec.rd         = w_rd;
      end
      c_op_auipc: begin
        w_dec.reg_write = 1'b1;
        w_dec.alu_src   = 1'b1;
        w_dec.alu_a_pc  = 1'b1;
        w_dec.imm_src   = 3'b100;
        w_dec.rd        = w_rd;
      end
      c_op_jal: begin
        w_dec.reg_write  = 1'b1;
        w_dec.jal        = 1'b1;
        w_dec.result_src = 2'b10;
        w_dec.imm_src    = 3'b011;
        w_dec.alu_ctrl   = 4'b1000;
        w_dec.rd         = w_rd;
      end
      default: w_bad = 1'b1;
    endcase
    // illegal instructions carry only the flag so nothing downstream writes
    if (w_bad) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
    end
    w_dec.valid = 1'b1;
    if (!bus.instr_valid_i) begin
      w_dec = '0;
    end
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_ex.br_f3)
      3'b000:  w_taken = bus.alu_zero_i;
      3'b001:  w_taken = !bus.alu_zero_i;
      3'b100:  w_taken = bus.alu_lt_i;
      3'b101:  w_taken = !bus.alu_lt_i;
      3'b110:  w_taken = bus.alu_ltu_i;
      3'b111:  w_taken = !bus.alu_ltu_i;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_pcsrc    = r_ex.valid & (r_ex.jal | r_ex.jalr | (r_ex.branch & w_taken));
  assign w_md_hold  = (r_md_cnt != '0);
  assign w_load_use = bus.instr_valid_i & r_ex.valid & (r_ex.result_src == 2'b01) &
                      (r_ex.rd != 5'd0) &
                      ((w_use_rs1 && (w_rs1 == r_ex.rd)) || (w_use_rs2 && (w_rs2 == r_ex.rd)));

  // flush beats M hold beats load-use bubble beats normal capture
  always_comb begin
    w_ex_nxt  = w_dec;
    w_capture = 1'b1;
    if (w_pcsrc) begin
      w_ex_nxt  = '0;
      w_capture = 1'b0;
    end else if (w_md_hold) begin
      w_ex_nxt  = r_ex;
      w_capture = 1'b0;
    end else if (w_load_use) begin
      w_ex_nxt  = '0;
      w_capture = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex     <= '0;
      r_md_cnt <= '0;
    end else begin
      r_ex <= w_ex_nxt;
      if (w_md_hold) begin
        r_md_cnt <= r_md_cnt - c_cnt_w'(1);
      end else if (w_capture && w_dec.muldiv) begin
        r_md_cnt <= c_md_load;
      end else begin
        r_md_cnt <= '0;
      end
    end
  end

  assign bus.stall_o            = !w_pcsrc & (w_md_hold | w_load_use);
  assign bus.pcsrc_o            = w_pcsrc;
  assign bus.ex_valid_o         = r_ex.valid;
  assign bus.ex_reg_write_o     = r_ex.valid & r_ex.reg_write;
  assign bus.ex_mem_write_o     = r_ex.valid & r_ex.mem_write;
  assign bus.ex_alu_src_o       = r_ex.alu_src;
  assign bus.ex_alu_a_pc_o      = r_ex.alu_a_pc;
  assign bus.ex_jalr_o          = r_ex.jalr;
  assign bus.ex_load_unsigned_o = r_ex.load_unsigned;
  assign bus.ex_muldiv_o        = r_ex.muldiv;
  assign bus.ex_illegal_o       = r_ex.illegal;
  assign bus.ex_result_src_o    = r_ex.result_src;
  assign bus.ex_imm_src_o       = r_ex.imm_src;
  assign bus.ex_alu_ctrl_o      = r_ex.alu_ctrl;
  assign bus.ex_data_width_o    = r_ex.data_width;
  assign bus.ex_md_op_o         = r_ex.md_op;
  assign bus.ex_rd_o            = r_ex.rd;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// tb_ctrl_pipe : directed scoreboard bench for ctrl_pipe
// Revision     : 1.0
// ============================================================================
module tb_ctrl_pipe;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    string       tag;
    logic [27:0] val;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  ctrl_pipe_if ifa ();
  ctrl_pipe_if ifb ();

  ctrl_pipe #(.HAS_M(1'b1), .MD_LATENCY(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  ctrl_pipe #(.HAS_M(1'b0), .MD_LATENCY(1)) dut_nom (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  assign ifb.instr_i       = ifa.instr_i;
  assign ifb.instr_valid_i = ifa.instr_valid_i;
  assign ifb.alu_zero_i    = ifa.alu_zero_i;
  assign ifb.alu_lt_i      = ifa.alu_lt_i;
  assign ifb.alu_ltu_i     = ifa.alu_ltu_i;

  // flags: valid reg_write mem_write alu_src alu_a_pc jalr load_unsigned muldiv illegal
  function automatic logic [27:0] mk(input logic [8:0] f, input logic [1:0] rs,
                                     input logic [2:0] is, input logic [3:0] ac,
                                     input logic [1:0] w, input logic [2:0] mo,
                                     input logic [4:0] rd);
    return {f, rs, is, ac, w, mo, rd};
  endfunction

  function automatic logic [27:0] obs_a();
    return {ifa.ex_valid_o, ifa.ex_reg_write_o, ifa.ex_mem_write_o, ifa.ex_alu_src_o,
            ifa.ex_alu_a_pc_o, ifa.ex_jalr_o, ifa.ex_load_unsigned_o, ifa.ex_muldiv_o,
            ifa.ex_illegal_o, ifa.ex_result_src_o, ifa.ex_imm_src_o, ifa.ex_alu_ctrl_o,
            ifa.ex_data_width_o, ifa.ex_md_op_o, ifa.ex_rd_o};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  // nonzero bits in the rd slot check that S/B never report a destination
  function automatic logic [31:0] enc_s(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [6:0] op);
    return {7'b0, rs2, rs1, f3, 5'b00110, op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  task automatic chk(input string tag, input logic [27:0] o, input logic [27:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] ins, input logic v,
                      input logic [2:0] fl, input logic es, input logic ep,
                      input logic [27:0] enext);
    sb_t e;
    ifa.instr_i       = ins;
    ifa.instr_valid_i = v;
    {ifa.alu_zero_i, ifa.alu_lt_i, ifa.alu_ltu_i} = fl;
    #1;
    chk({tag, ".stall"}, 28'(ifa.stall_o), 28'(es));
    chk({tag, ".pcsrc"}, 28'(ifa.pcsrc_o), 28'(ep));
    sb.push_back('{tag, enext});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, ".ex"}, obs_a(), e.val);
  endtask

  // {f3, zero, lt, ltu, taken}
  logic [6:0] br_tab [12] = '{
    {3'b000, 3'b100, 1'b1}, {3'b000, 3'b011, 1'b0},
    {3'b001, 3'b000, 1'b1}, {3'b001, 3'b100, 1'b0},
    {3'b100, 3'b010, 1'b1}, {3'b100, 3'b001, 1'b0},
    {3'b101, 3'b001, 1'b1}, {3'b101, 3'b010, 1'b0},
    {3'b110, 3'b001, 1'b1}, {3'b110, 3'b010, 1'b0},
    {3'b111, 3'b010, 1'b1}, {3'b111, 3'b001, 1'b0}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] e_lw5, e_add6, e_lw0, e_bub, e_b, e_addi, e_mulh, e_ill;
    logic [31:0] i_lw5, i_add6, i_addi, i_mulh;
    logic [6:0]  row;

    e_bub  = '0;
    e_lw5  = mk(9'b110100000, 2'b01, 3'b000, 4'b0000, 2'b00, 3'b000, 5'd5);
    e_add6 = mk(9'b110000000, 2'b00, 3'b000, 4'b0000, 2'b00, 3'b000, 5'd6);
    e_lw0  = mk(9'b110100000, 2'b01, 3'b000, 4'b0000, 2'b00, 3'b000, 5'd0);
    e_b    = mk(9'b100000000, 2'b00, 3'b010, 4'b1000, 2'b00, 3'b000, 5'd0);
    e_addi = mk(9'b110100000, 2'b00, 3'b000, 4'b0000, 2'b00, 3'b000, 5'd12);
    e_mulh = mk(9'b110000010, 2'b00, 3'b000, 4'b0001, 2'b00, 3'b001, 5'd13);
    e_ill  = mk(9'b100000001, 2'b00, 3'b000, 4'b0000, 2'b00, 3'b000, 5'd0);

    i_lw5  = enc_i(12'd0, 5'd1, 3'b010, 5'd5, OP_LOAD);
    i_add6 = enc_r(7'b0, 5'd2, 5'd5, 3'b000, 5'd6);
    i_addi = enc_i(12'd0, 5'd1, 3'b000, 5'd12, OP_IMM);
    i_mulh = enc_r(7'b0000001, 5'd2, 5'd1, 3'b001, 5'd13);

    ifa.instr_i       = i_lw5;
    ifa.instr_valid_i = 1'b1;
    {ifa.alu_zero_i, ifa.alu_lt_i, ifa.alu_ltu_i} = 3'b000;
    @(negedge clk);
    @(negedge clk);
    chk("rst.ex", obs_a(), e_bub);
    chk("rst.stall", 28'(ifa.stall_o), 28'd0);
    chk("rst.pcsrc", 28'(ifa.pcsrc_o), 28'd0);
    rst_n = 1'b1;

    step("lw5",      i_lw5,  1'b1, 3'b000, 1'b0, 1'b0, e_lw5);
    step("lu.add",   i_add6, 1'b1, 3'b000, 1'b1, 1'b0, e_bub);
    step("lu.add2",  i_add6, 1'b1, 3'b000, 1'b0, 1'b0, e_add6);
    step("lw0",      enc_i(12'd0, 5'd1, 3'b010, 5'd0, OP_LOAD), 1'b1, 3'b000, 1'b0, 1'b0, e_lw0);
    step("add.x0",   enc_r(7'b0, 5'd2, 5'd0, 3'b000, 5'd6), 1'b1, 3'b000, 1'b0, 1'b0, e_add6);
    step("lw7",      enc_i(12'd0, 5'd1, 3'b010, 5'd7, OP_LOAD), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b110100000, 2'b01, 3'b000, 4'b0000, 2'b00, 3'b000, 5'd7));
    step("add.unrel", enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd8), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b110000000, 2'b00, 3'b000, 4'b0000, 2'b00, 3'b000, 5'd8));
    step("lw9",      enc_i(12'd0, 5'd1, 3'b010, 5'd9, OP_LOAD), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b110100000, 2'b01, 3'b000, 4'b0000, 2'b00, 3'b000, 5'd9));
    step("sw.lu",    enc_s(5'd9, 5'd3, 3'b010, OP_S), 1'b1, 3'b000, 1'b1, 1'b0, e_bub);
    step("sw",       enc_s(5'd9, 5'd3, 3'b010, OP_S), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b101100000, 2'b00, 3'b001, 4'b0000, 2'b00, 3'b000, 5'd0));
    step("lw5b",     i_lw5, 1'b1, 3'b000, 1'b0, 1'b0, e_lw5);
    // the rs1 field of this lui aliases x5; lui must not stall on it
    step("lui",      enc_u(20'h00028, 5'd11, OP_LUI), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b110000000, 2'b11, 3'b100, 4'b0000, 2'b00, 3'b000, 5'd11));

    for (int i = 0; i < 12; i++) begin
      row = br_tab[i];
      step($sformatf("br%0d", i), enc_s(5'd2, 5'd1, row[6:4], OP_B), 1'b1, 3'b000,
           1'b0, 1'b0, e_b);
      step($sformatf("br%0d.res", i), i_addi, 1'b1, row[3:1], 1'b0, row[0],
           row[0] ? e_bub : e_addi);
    end

    step("bub",      32'd0, 1'b0, 3'b000, 1'b0, 1'b0, e_bub);
    step("mulh",     i_mulh, 1'b1, 3'b000, 1'b0, 1'b0, e_mulh);
    chk("nom.valid", 28'(ifb.ex_valid_o), 28'd1);
    chk("nom.ill",   28'(ifb.ex_illegal_o), 28'd1);
    chk("nom.rw",    28'(ifb.ex_reg_write_o), 28'd0);
    chk("nom.md",    28'(ifb.ex_muldiv_o), 28'd0);
    for (int i = 0; i < 3; i++)
      step($sformatf("md.hold%0d", i), enc_r(7'b0, 5'd2, 5'd13, 3'b000, 5'd14), 1'b1,
           3'b000, 1'b1, 1'b0, e_mulh);
    step("md.add",   enc_r(7'b0, 5'd2, 5'd13, 3'b000, 5'd14), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b110000000, 2'b00, 3'b000, 4'b0000, 2'b00, 3'b000, 5'd14));

    step("mulh2",    i_mulh, 1'b1, 3'b000, 1'b0, 1'b0, e_mulh);
    for (int i = 0; i < 3; i++)
      step($sformatf("md.lw%0d", i), enc_i(12'd0, 5'd1, 3'b010, 5'd15, OP_LOAD), 1'b1,
           3'b000, 1'b1, 1'b0, e_mulh);
    step("md.lw",    enc_i(12'd0, 5'd1, 3'b010, 5'd15, OP_LOAD), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b110100000, 2'b01, 3'b000, 4'b0000, 2'b00, 3'b000, 5'd15));
    step("md.lu",    enc_r(7'b0, 5'd2, 5'd15, 3'b000, 5'd16), 1'b1, 3'b000, 1'b1, 1'b0, e_bub);
    step("md.add16", enc_r(7'b0, 5'd2, 5'd15, 3'b000, 5'd16), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b110000000, 2'b00, 3'b000, 4'b0000, 2'b00, 3'b000, 5'd16));

    step("srai",     enc_i({7'b0100000, 5'd3}, 5'd1, 3'b101, 5'd17, OP_IMM), 1'b1, 3'b000,
         1'b0, 1'b0, mk(9'b110100000, 2'b00, 3'b000, 4'b1101, 2'b00, 3'b000, 5'd17));
    step("auipc",    enc_u(20'h12345, 5'd18, OP_AUIPC), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b110110000, 2'b00, 3'b100, 4'b0000, 2'b00, 3'b000, 5'd18));
    step("lbu",      enc_i(12'd0, 5'd1, 3'b100, 5'd19, OP_LOAD), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b110100100, 2'b01, 3'b000, 4'b0000, 2'b10, 3'b000, 5'd19));
    step("jal",      enc_u(20'h00098, 5'd20, OP_JAL), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b110000000, 2'b10, 3'b011, 4'b1000, 2'b00, 3'b000, 5'd20));
    step("jal.flush", enc_r(7'b0, 5'd20, 5'd19, 3'b000, 5'd21), 1'b1, 3'b000, 1'b0, 1'b1, e_bub);
    step("jalr",     enc_i(12'd0, 5'd1, 3'b000, 5'd22, OP_JALR), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b110101000, 2'b10, 3'b000, 4'b1000, 2'b00, 3'b000, 5'd22));
    step("jalr.flush", i_addi, 1'b1, 3'b000, 1'b0, 1'b1, e_bub);

    step("ill.op",   enc_i(12'd0, 5'd1, 3'b000, 5'd23, 7'b1111111), 1'b1, 3'b000, 1'b0, 1'b0, e_ill);
    step("ill.ld",   enc_i(12'd0, 5'd1, 3'b011, 5'd23, OP_LOAD), 1'b1, 3'b000, 1'b0, 1'b0, e_ill);
    step("ill.st",   enc_s(5'd2, 5'd1, 3'b100, OP_S), 1'b1, 3'b000, 1'b0, 1'b0, e_ill);

    step("mulh3",    i_mulh, 1'b1, 3'b000, 1'b0, 1'b0, e_mulh);
    ifa.instr_i       = enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd24);
    ifa.instr_valid_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.ex",    obs_a(), e_bub);
    chk("arst.stall", 28'(ifa.stall_o), 28'd0);
    chk("arst.pcsrc", 28'(ifa.pcsrc_o), 28'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd24), 1'b1, 3'b000, 1'b0, 1'b0,
         mk(9'b110000000, 2'b00, 3'b000, 4'b0000, 2'b00, 3'b000, 5'd24));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
